// File: rtl/attach_vb_pkg.sv
// attach_vb_pkg: shared types and default constants for the VB attach stage.
//   send_state_t : frame sender states (IDLE, FWD, VB, TRL, TERM)
//   cap_state_t  : per-channel capture states (IDLE, CAPT, READY)
package attach_vb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FWD,
      S_VB,
      S_TRL,
      S_TERM
   } send_state_t;

   typedef enum logic [1:0] {
      C_IDLE,
      C_CAPT,
      C_READY
   } cap_state_t;

   localparam logic [15:0] HDR_DEFAULT = 16'hAAAA;
   localparam logic [15:0] TRL_DEFAULT = 16'h5554;

endpackage

// File: rtl/vb_capture.sv
// vb_capture: one VB channel. Captures VB_LEN words after a header, holds
// them until consumed by a frame or aged out after TIMEOUT cycles.
//   clk, rst     : clock, synchronous active-low reset
//   vb           : channel input stream
//   snap_take    : sender is latching its snapshot this cycle
//   frozen       : channel belongs to the frame in progress (age held)
//   consume      : frame finished with this channel's packet
//   rd_idx       : buffer read index; rd_data is the combinational read
//   ready        : registered level, complete unconsumed packet held
//   drop         : registered one-cycle pulse on timeout
module vb_capture
   import attach_vb_pkg::*;
#(
   parameter int unsigned W       = 16,
   parameter int unsigned VB_LEN  = 16,
   parameter int unsigned TIMEOUT = 95,
   parameter int unsigned IW      = 4,
   parameter logic [W-1:0] HDR    = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  vb,
   input  logic          snap_take,
   input  logic          frozen,
   input  logic          consume,
   input  logic [IW-1:0] rd_idx,
   output logic [W-1:0]  rd_data,
   output logic          ready,
   output logic          drop
);

   localparam int unsigned CNTW = $clog2(VB_LEN + 1);
   localparam int unsigned AGEW = $clog2(TIMEOUT + 1);

   cap_state_t      state, state_d;
   logic [CNTW-1:0] widx;
   logic [AGEW-1:0] age;
   logic [W-1:0]    mem [VB_LEN];
   logic            timeout_c;
   logic            store_c;

   // A snapshot taken on the expiry cycle keeps the packet.
   assign timeout_c = (state == C_READY) && !frozen && !snap_take &&
                      (age == AGEW'(TIMEOUT - 1));
   assign store_c   = (state == C_CAPT) && (widx < CNTW'(VB_LEN));
   assign rd_data   = mem[rd_idx];

   // Next-state logic; header words outside IDLE are plain data.
   always_comb begin
      state_d = state;
      case (state)
         C_IDLE:  if (vb == HDR) state_d = C_CAPT;
         C_CAPT:  if (widx == CNTW'(VB_LEN)) state_d = C_READY;
         C_READY: if (consume || timeout_c) state_d = C_IDLE;
         default: state_d = C_IDLE;
      endcase
   end

   // State, counters and registered status.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= C_IDLE;
         widx  <= '0;
         age   <= '0;
         ready <= 1'b0;
         drop  <= 1'b0;
      end else begin
         state <= state_d;
         ready <= (state_d == C_READY);
         drop  <= timeout_c;
         case (state)
            C_IDLE: begin
               widx <= '0;
               age  <= '0;
            end
            C_CAPT: begin
               if (store_c) widx <= widx + CNTW'(1);
               age <= age + AGEW'(1);
            end
            C_READY: begin
               if (!frozen) age <= age + AGEW'(1);
            end
            default: begin
               widx <= '0;
               age  <= '0;
            end
         endcase
      end
   end

   // Packet buffer, no reset needed.
   always_ff @(posedge clk) begin
      if (store_c) mem[widx[IW-1:0]] <= vb;
   end

endmodule

// File: rtl/attach_vb_mux.sv
// attach_vb_mux: forwards CB frames and appends each VB channel's captured
// packet (or zeros), then a trailer word and a zero terminator.
//   clk, rst  : clock, synchronous active-low reset
//   vb        : NCH VB streams, channel c at [c*W +: W]
//   cb        : CB stream
//   out       : registered merged output word
//   out_valid : high for every output frame word
//   frame_end : pulse with the terminator word
//   vb_drop   : per-channel timeout drop pulse
//   vb_ready  : per-channel packet-held level
module attach_vb_mux
   import attach_vb_pkg::*;
#(
   parameter int unsigned W       = 16,
   parameter int unsigned NCH     = 2,
   parameter int unsigned VB_LEN  = 16,
   parameter int unsigned CB_LEN  = 50,
   parameter logic [W-1:0] HDR    = W'(HDR_DEFAULT),
   parameter logic [W-1:0] TRL    = W'(TRL_DEFAULT),
   parameter int unsigned TIMEOUT = 95
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH*W-1:0] vb,
   input  logic [W-1:0]     cb,
   output logic [W-1:0]     out,
   output logic             out_valid,
   output logic             frame_end,
   output logic [NCH-1:0]   vb_drop,
   output logic [NCH-1:0]   vb_ready
);

   localparam int unsigned IW = (VB_LEN > 1) ? $clog2(VB_LEN) : 1;
   localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned FW = $clog2(CB_LEN + 1);

   send_state_t    state, state_d;
   logic [FW-1:0]  fcnt;
   logic [IW-1:0]  idx;
   logic [CW-1:0]  ch;
   logic [NCH-1:0] snap;
   logic [NCH-1:0] consume_c;
   logic [W-1:0]   rd_data [NCH];
   logic           snap_take_c;
   logic           vb_last_c;
   logic [W-1:0]   out_nxt;
   logic           valid_nxt;
   logic           fend_nxt;

   assign snap_take_c = (state == S_FWD) && (fcnt == FW'(CB_LEN - 1));
   assign vb_last_c   = (state == S_VB) && (idx == IW'(VB_LEN - 1)) &&
                        (ch == CW'(NCH - 1));
   assign consume_c   = (state == S_TERM) ? snap : '0;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      vb_capture #(
         .W       (W),
         .VB_LEN  (VB_LEN),
         .TIMEOUT (TIMEOUT),
         .IW      (IW),
         .HDR     (HDR)
      ) u_cap (
         .clk       (clk),
         .rst       (rst),
         .vb        (vb[c*W +: W]),
         .snap_take (snap_take_c),
         .frozen    (snap[c]),
         .consume   (consume_c[c]),
         .rd_idx    (idx),
         .rd_data   (rd_data[c]),
         .ready     (vb_ready[c]),
         .drop      (vb_drop[c])
      );
   end

   // Sender next state; cb headers after IDLE are forwarded as data.
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (cb == HDR) state_d = S_FWD;
         S_FWD:   if (snap_take_c) state_d = S_VB;
         S_VB:    if (vb_last_c) state_d = S_TRL;
         S_TRL:   state_d = S_TERM;
         S_TERM:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next output word, registered one cycle later.
   always_comb begin
      out_nxt   = '0;
      valid_nxt = 1'b0;
      fend_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (cb == HDR) begin
               out_nxt   = cb;
               valid_nxt = 1'b1;
            end
         end
         S_FWD: begin
            out_nxt   = cb;
            valid_nxt = 1'b1;
         end
         S_VB: begin
            out_nxt   = snap[ch] ? rd_data[ch] : '0;
            valid_nxt = 1'b1;
         end
         S_TRL: begin
            out_nxt   = TRL;
            valid_nxt = 1'b1;
         end
         S_TERM: begin
            valid_nxt = 1'b1;
            fend_nxt  = 1'b1;
         end
         default: ;
      endcase
   end

   // State register, counters, snapshot and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         fcnt      <= '0;
         idx       <= '0;
         ch        <= '0;
         snap      <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         frame_end <= 1'b0;
      end else begin
         state     <= state_d;
         out       <= out_nxt;
         out_valid <= valid_nxt;
         frame_end <= fend_nxt;
         case (state)
            S_IDLE: begin
               fcnt <= FW'(1);
               idx  <= '0;
               ch   <= '0;
            end
            S_FWD: begin
               if (snap_take_c) snap <= vb_ready;
               else             fcnt <= fcnt + FW'(1);
            end
            S_VB: begin
               if (idx == IW'(VB_LEN - 1)) begin
                  idx <= '0;
                  if (!vb_last_c) ch <= ch + CW'(1);
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            S_TERM: snap <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_attach_vb_mux.sv
// tb_attach_vb_mux: directed self-checking bench for attach_vb_mux with
// default parameters (W=16, NCH=2, VB_LEN=16, CB_LEN=50, TIMEOUT=95).
module tb_attach_vb_mux;

   localparam int unsigned W       = 16;
   localparam int unsigned NCH     = 2;
   localparam int unsigned VB_LEN  = 16;
   localparam int unsigned CB_LEN  = 50;
   localparam int unsigned TIMEOUT = 95;
   localparam logic [15:0] HDR     = 16'hAAAA;
   localparam logic [15:0] TRL     = 16'h5554;
   localparam int          F       = CB_LEN + NCH * VB_LEN + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] vb  = '0;
   logic [15:0] cb  = '0;
   logic [15:0] out;
   logic        out_valid;
   logic        frame_end;
   logic [1:0]  vb_drop;
   logic [1:0]  vb_ready;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_vb [NCH][VB_LEN];

   always #5 clk = ~clk;

   attach_vb_mux #(
      .W       (W),
      .NCH     (NCH),
      .VB_LEN  (VB_LEN),
      .CB_LEN  (CB_LEN),
      .HDR     (HDR),
      .TRL     (TRL),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .vb        (vb),
      .cb        (cb),
      .out       (out),
      .out_valid (out_valid),
      .frame_end (frame_end),
      .vb_drop   (vb_drop),
      .vb_ready  (vb_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] cbw(input int i);
      return 16'h1000 + 16'(i);
   endfunction

   // Header then VB_LEN words on the masked channels; word k = base + k,
   // except channel 0 word hdr_pos0 which carries the header value.
   task automatic load_vb(input logic [1:0] mask, input logic [15:0] base0,
                          input logic [15:0] base1, input int hdr_pos0);
      logic [15:0] w;
      for (int k = 0; k <= int'(VB_LEN); k++) begin
         for (int c = 0; c < 2; c++) begin
            if (mask[c]) begin
               if (k == 0) w = HDR;
               else if (c == 0 && k == hdr_pos0) w = HDR;
               else w = ((c == 0) ? base0 : base1) + 16'(k);
               vb[c*16 +: 16] = w;
               if (k > 0) exp_vb[c][k-1] = w;
            end
         end
         tick();
      end
      vb = '0;
      tick();
      tick();
   endtask

   // Drive one CB frame and check every output word plus the idle cycle after.
   task automatic run_frame(input logic s0, input logic s1, input int mid_hdr,
                            input int vb1_at, input string tag);
      logic [15:0] exp;
      logic [15:0] w;
      for (int i = 0; i < F; i++) begin
         if (i == 0) cb = HDR;
         else if (i < int'(CB_LEN)) cb = (i == mid_hdr) ? HDR : cbw(i);
         else cb = '0;
         if (vb1_at >= 0) begin
            if (i == vb1_at) vb[31:16] = HDR;
            else if (i > vb1_at && i <= vb1_at + int'(VB_LEN)) begin
               w = 16'h2000 + 16'(i - vb1_at);
               vb[31:16] = w;
               exp_vb[1][i-vb1_at-1] = w;
            end else vb[31:16] = '0;
         end
         tick();
         if (i == 0) exp = HDR;
         else if (i < int'(CB_LEN)) exp = (i == mid_hdr) ? HDR : cbw(i);
         else if (i < int'(CB_LEN + VB_LEN)) exp = s0 ? exp_vb[0][i-int'(CB_LEN)] : 16'h0;
         else if (i < int'(CB_LEN + 2*VB_LEN)) exp = s1 ? exp_vb[1][i-int'(CB_LEN+VB_LEN)] : 16'h0;
         else if (i == F - 2) exp = TRL;
         else exp = 16'h0;
         check_eq($sformatf("%s out[%0d]", tag, i), 32'(out), 32'(exp));
         check_eq($sformatf("%s vld_fe[%0d]", tag, i), {30'b0, out_valid, frame_end},
                  {30'b0, 1'b1, (i == F - 1)});
      end
      cb = '0;
      tick();
      check_eq({tag, " idle_out"}, 32'(out), 32'h0);
      check_eq({tag, " idle_vld_fe"}, {30'b0, out_valid, frame_end}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      rst = 1'b0;
      tick();
      tick();
      check_eq("rst out", 32'(out), 32'h0);
      check_eq("rst out_valid", 32'(out_valid), 32'h0);
      check_eq("rst frame_end", 32'(frame_end), 32'h0);
      check_eq("rst vb_drop", 32'(vb_drop), 32'h0);
      check_eq("rst vb_ready", 32'(vb_ready), 32'h0);
      rst = 1'b1;
      tick();

      // VB0 words 1..16, VB1 absent
      load_vb(2'b01, 16'h0000, 16'h0000, -1);
      check_eq("t1 ready", 32'(vb_ready), 32'h1);
      run_frame(1'b1, 1'b0, -1, -1, "t1");
      check_eq("t1 ready_after", 32'(vb_ready), 32'h0);

      // Both channels, HDR inside VB0 packet, second cb HDR mid-frame
      load_vb(2'b11, 16'h0100, 16'h0200, 5);
      check_eq("t2 ready", 32'(vb_ready), 32'h3);
      run_frame(1'b1, 1'b1, 20, -1, "t2");
      check_eq("t2 ready_after", 32'(vb_ready), 32'h0);

      // Timeout: header at edge t, drop pulse at edge t+95
      load_vb(2'b01, 16'h0300, 16'h0000, -1);
      repeat (94 - 18) tick();
      check_eq("t3 drop_early", 32'(vb_drop), 32'h0);
      check_eq("t3 ready_early", 32'(vb_ready), 32'h1);
      tick();
      check_eq("t3 drop", 32'(vb_drop), 32'h1);
      check_eq("t3 ready_dropped", 32'(vb_ready), 32'h0);
      tick();
      check_eq("t3 drop_pulse", 32'(vb_drop), 32'h0);
      run_frame(1'b0, 1'b0, -1, -1, "t3");

      // VB1 header 5 cycles before FWD ends: zeros now, data next frame
      run_frame(1'b0, 1'b0, -1, int'(CB_LEN) - 6, "t4a");
      check_eq("t4 ready_pending", 32'(vb_ready), 32'h2);
      check_eq("t4 no_drop", 32'(vb_drop), 32'h0);
      run_frame(1'b0, 1'b1, -1, -1, "t4b");
      check_eq("t4 ready_after", 32'(vb_ready), 32'h0);

      // Reset during VB phase
      load_vb(2'b11, 16'h0400, 16'h0500, -1);
      cb = HDR;
      tick();
      for (int i = 1; i < int'(CB_LEN); i++) begin
         cb = cbw(i);
         tick();
      end
      cb = '0;
      repeat (5) tick();
      check_eq("t5 mid_vld", 32'(out_valid), 32'h1);
      check_eq("t5 mid_out", 32'(out), 32'(exp_vb[0][4]));
      rst = 1'b0;
      tick();
      check_eq("t5 rst_out", 32'(out), 32'h0);
      check_eq("t5 rst_vld", 32'(out_valid), 32'h0);
      check_eq("t5 rst_fe", 32'(frame_end), 32'h0);
      check_eq("t5 rst_ready", 32'(vb_ready), 32'h0);
      rst = 1'b1;
      tick();
      check_eq("t5 post_vld", 32'(out_valid), 32'h0);
      run_frame(1'b0, 1'b0, -1, -1, "t5");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/attach_vb_mux.md
# attach_vb_mux

Parametrised successor to the single-channel VB attach stage. Captures fixed-length VB packets from `NCH` independent VB inputs into per-channel buffers, then appends them to the next CB frame passing through. Output frame layout: CB header + CB payload, each channel's VB block (or zeros), trailer word, terminator zero. Channels whose captured packet is not consumed within `TIMEOUT` cycles are dropped and reported. Sits between the CB source and the downstream serializer in the readout chain.

## Interface
- `W`, 16: data word width.
- `NCH`, 2: number of VB channels, 1..8.
- `VB_LEN`, 16: words captured per VB packet (header excluded).
- `CB_LEN`, 50: CB words forwarded, header cycle included.
- `HDR`, 16'hAAAA: header word (VB and CB).
- `TRL`, 16'h5554: trailer word.
- `TIMEOUT`, 95: cycles from VB header to drop if not emitted; ≥ `VB_LEN`+2.

- `clk`  in  1  single clock, all logic posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `vb`  in  `NCH*W`  VB streams; channel c = bits [c*W +: W].
- `cb`  in  `W`  CB stream.
- `out`  out  `W`  merged output word, registered.
- `out_valid`  out  1  high for every word of an output frame.
- `frame_end`  out  1  one-cycle pulse with the terminator word.
- `vb_drop`  out  `NCH`  one-cycle pulse per channel on timeout drop.
- `vb_ready`  out  `NCH`  level: channel holds a complete, unconsumed packet.

## Operation
- Reset (`rst`=0 at posedge): all channels IDLE, sender IDLE, `out`=0, `out_valid`=0, `frame_end`=0, `vb_drop`=0, `vb_ready`=0; buffer contents don't-care.
- Per-channel capture FSM: IDLE → CAPT on `vb[c]`==`HDR`; CAPT stores the next `VB_LEN` words at index 0..`VB_LEN`-1 → READY. READY → IDLE when consumed by a frame or when age reaches `TIMEOUT` (pulse `vb_drop[c]`). `HDR` seen in CAPT/READY is data/ignored — no restart, no overwrite.
- Age counter per channel: clears on header, increments each cycle in CAPT/READY, frozen while channel is snapshotted for an in-progress frame.
- Sender FSM: IDLE → FWD on `cb`==`HDR`. FWD: `out`=`cb` for `CB_LEN` cycles (header first). At FWD→VB transition latch snapshot = channels in READY. VB: for c=0..NCH-1, emit `VB_LEN` words: buffer[c][i] if snapshot[c], else 0. Then TRL state emits `TRL`, TERM emits 0 with `frame_end`=1, → IDLE; snapshotted channels → IDLE (`vb_ready` falls).
- `cb` header during FWD/VB/TRL/TERM: treated as data/ignored. The next frame needs a header received while IDLE (earliest: cycle after TERM).
- Channel in CAPT at snapshot: emitted as zeros; capture continues unaffected; packet waits for the next frame.
- Timeout and snapshot same cycle: snapshot wins, no drop.
- Sender IDLE: `out`=0, `out_valid`=0.
- Widths: counters sized `$clog2` of max count + 1; no wrap permitted within a frame.

## Timing
- `cb` header at edge t → `out`=HDR, `out_valid`=1 at t+1 (1-cycle latency, all `out` words).
- Frame length F = `CB_LEN` + `NCH`*`VB_LEN` + 2 cycles; defaults = 84.
- VB header at edge t → first word stored at t+1, READY from t+`VB_LEN`+1.
- Drop: `vb_drop[c]` at edge t+`TIMEOUT` after header edge t, if not snapshotted.
- Reset mid-frame: output returns to 0/invalid next cycle; no partial trailer.

## Structure
- Package `attach_vb_pkg`: sender state enum (IDLE, FWD, VB, TRL, TERM), capture state enum (IDLE, CAPT, READY), default `HDR`/`TRL` constants.
- Sub-module `vb_capture`: one channel's FSM, `VB_LEN`×`W` buffer, age counter, read port; instantiated `NCH` times via generate. Top holds sender FSM, snapshot, output mux.

## Test plan
- Defaults, VB0 header + words 1..16, then CB header + 49 words → 84-word frame: CB words, VB0 1..16, 16 zeros for VB1, 0x5554, 0 with `frame_end`.
- Both channels loaded, CB frame → VB0 then VB1 blocks in order; `vb_ready` = 2'b11 → 2'b00 after TERM.
- VB0 header, no CB for 95 cycles → `vb_drop[0]` pulse at t+95; following frame carries zeros for VB0.
- VB1 header 5 cycles before FWD ends (still CAPT) → zeros in frame; next frame carries VB1 data.
- Second `cb` HDR mid-frame and `vb` HDR inside a captured packet → forwarded/stored as data, no restart.
- `rst`=0 during VB phase → `out`=0, `out_valid`=0 next cycle; all `vb_ready` cleared.
